// File: rtl/la_spram_arbiter_pkg.sv
// Shared definitions for the la_spram round-robin arbiter.
// Holds the pointer/owner width helpers, the lock state encoding and an
// index-to-one-hot helper used when the LA_SPRAM_ARBITER_LOCK_EN build
// restricts arbitration to the lock owner.
package la_spram_arbiter_pkg;

    localparam int MAX_N = 16;

    // A requester either holds the RAM for a burst or it does not.
    typedef enum logic {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    // Width of the round-robin pointer; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The lock owner field stores a requester index, same as the pointer.
    function automatic int owner_width(input int n);
        return ptr_width(n);
    endfunction

    // One-hot vector of the widest supported arbiter; callers truncate to N.
    function automatic logic [MAX_N-1:0] idx_to_onehot(input logic [3:0] idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/la_spram_arbiter_if.sv
// Request/response bundle between N requesters and the la_spram arbiter.
// Address, mask and data buses are flattened: requester i owns the slice
// [i*AW +: AW] / [i*DW +: DW].
interface la_spram_arbiter_if #(
    parameter int N  = 2,
    parameter int DW = 32,
    parameter int AW = 10
);
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we;
    logic [N-1:0]    req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wmask;
    logic [N*DW-1:0] req_din;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_dout;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wmask, req_din,
        input  req_ready, rsp_valid, rsp_dout
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wmask, req_din,
        output req_ready, rsp_valid, rsp_dout
    );
endinterface

// File: rtl/la_spram_arbiter_rrarb.sv
// la_rrarb: purely combinational round-robin priority picker.
// The search starts at ptr+1 and wraps modulo N, so the requester granted
// last has the lowest priority next time.
module la_rrarb
    import la_spram_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    localparam int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    int   idx;
    logic found;

    // Walk the requesters in rotated order and keep the first one found
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && ((req >> idx) & N'(1)) != '0) begin
                grant = N'(1) << idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/la_spram_arbiter.sv
// la_spram_arbiter: shares one la_spram single-port RAM among N requesters.
// The granted request is driven to the RAM in the same cycle; read data
// comes back one cycle later to the requester recorded in rd_pend.
// Optional feature macro: LA_SPRAM_ARBITER_LOCK_EN (atomic locked bursts).
module la_spram_arbiter
    import la_spram_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              nreset,
    la_spram_arbiter_if.slave bus,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wmask,
    output logic [DW-1:0]     mem_din,
    input  logic [DW-1:0]     mem_dout
);

    localparam int PW = ptr_width(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [N-1:0]  eligible;
    logic [N-1:0]  grant;
    logic [N-1:0]  rd_pend;
    logic          xfer;

`ifdef LA_SPRAM_ARBITER_LOCK_EN
    localparam int OW = owner_width(N);

    lock_state_e   lock_state;
    lock_state_e   lock_state_d;
    logic [OW-1:0] owner;
    logic [OW-1:0] owner_d;
    logic [N-1:0]  owner_mask;

    // While a burst is locked only the owner may compete; nobody during reset
    always_comb begin
        owner_mask = {N{1'b1}};
        if (lock_state == LOCK_HELD) begin
            owner_mask = N'(idx_to_onehot(4'(owner)));
        end
        eligible = bus.req_valid & owner_mask & {N{nreset}};
    end

    // Every transfer decides whether its requester keeps the RAM afterwards
    always_comb begin
        lock_state_d = lock_state;
        owner_d      = owner;
        if (xfer) begin
            owner_d      = gidx;
            lock_state_d = bus.req_lock[gidx] ? LOCK_HELD : LOCK_FREE;
        end
    end

    // Lock state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lock_state <= LOCK_FREE;
            owner      <= '0;
        end else begin
            lock_state <= lock_state_d;
            owner      <= owner_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^bus.req_lock;

    // Plain round-robin: every valid requester competes, nobody during reset
    always_comb begin
        eligible = bus.req_valid & {N{nreset}};
    end
`endif

    la_rrarb #(.N(N)) u_rrarb (
        .req   (eligible),
        .ptr   (ptr),
        .grant (grant)
    );

    // Encode the grant and steer the winner's fields onto the RAM pins
    always_comb begin
        gidx      = '0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_din   = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                gidx      = PW'(i);
                mem_ce    = 1'b1;
                mem_we    = bus.req_we[i];
                mem_addr  = bus.req_addr[i*AW +: AW];
                mem_wmask = bus.req_wmask[i*DW +: DW];
                mem_din   = bus.req_din[i*DW +: DW];
            end
        end
    end

    assign xfer = mem_ce;

    // Round-robin pointer and the one-cycle read response tracker
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr     <= PW'(N - 1);
            rd_pend <= '0;
        end else begin
            if (xfer) begin
                ptr <= gidx;
            end
            rd_pend <= grant & ~bus.req_we;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rd_pend;
    assign bus.rsp_dout  = mem_dout;

endmodule

// File: tb/tb_la_spram_arbiter.sv
// Directed testbench for la_spram_arbiter with N=4 and a behavioural
// single-port RAM (registered read-first output, per-bit write mask).
module tb_la_spram_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          nreset;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wmask;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] ram [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    la_spram_arbiter_if #(.N(N), .DW(DW), .AW(AW)) bus ();

    la_spram_arbiter #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .bus       (bus),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wmask (mem_wmask),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural la_spram: masked write, read-first registered output
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) begin
                ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_din & mem_wmask);
            end
            mem_dout <= ram[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idleAll();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wmask = '0;
        bus.req_din   = '0;
    endtask

    task automatic applyStimulus(input int i, input logic we, input logic lock,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wmask,
                                 input logic [DW-1:0] din);
        bus.req_valid[i]           = 1'b1;
        bus.req_we[i]              = we;
        bus.req_lock[i]            = lock;
        bus.req_addr[i*AW +: AW]   = addr;
        bus.req_wmask[i*DW +: DW]  = wmask;
        bus.req_din[i*DW +: DW]    = din;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        idleAll();
    endtask

    initial begin
        nreset = 1'b0;
        idleAll();
        applyStimulus(0, 1'b0, 1'b0, 10'd5, '0, '0);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("rst_rsp",   32'(bus.rsp_valid), 32'h0);
        checkOutput("rst_ce",    32'(mem_ce),        32'h0);
        checkOutput("rst_we",    32'(mem_we),        32'h0);
        checkOutput("rst_ptr",   32'(dut.ptr),       32'h3);

        nextCycle();
        nreset = 1'b1;
        #1;
        checkOutput("post_rst_rsp", 32'(bus.rsp_valid), 32'h0);

        // Single requester write then read back
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 10'd5, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        #1;
        checkOutput("wr_ready", 32'(bus.req_ready), 32'h1);
        checkOutput("wr_ce",    32'(mem_ce),        32'h1);
        checkOutput("wr_we",    32'(mem_we),        32'h1);
        checkOutput("wr_addr",  32'(mem_addr),      32'd5);
        checkOutput("wr_din",   mem_din,            32'hDEAD_BEEF);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 10'd5, '0, '0);
        #1;
        checkOutput("rd_ready",  32'(bus.req_ready), 32'h1);
        checkOutput("rd_we",     32'(mem_we),        32'h0);
        checkOutput("wr_no_rsp", 32'(bus.rsp_valid), 32'h0);
        nextCycle();
        #1;
        checkOutput("rd_rsp",     32'(bus.rsp_valid), 32'h1);
        checkOutput("rd_dout",    bus.rsp_dout,       32'hDEAD_BEEF);
        checkOutput("idle_ce",    32'(mem_ce),        32'h0);
        checkOutput("idle_addr",  32'(mem_addr),      32'h0);

        // Masked write by requester 2
        nextCycle();
        applyStimulus(2, 1'b1, 1'b0, 10'd9, 32'hFFFF_FFFF, 32'h1234_5678);
        #1;
        checkOutput("mw_ready", 32'(bus.req_ready), 32'h4);
        nextCycle();
        applyStimulus(2, 1'b1, 1'b0, 10'd9, 32'h0000_FFFF, 32'hFFFF_0000);
        #1;
        checkOutput("mw_wmask", mem_wmask, 32'h0000_FFFF);
        nextCycle();
        applyStimulus(2, 1'b0, 1'b0, 10'd9, '0, '0);
        nextCycle();
        #1;
        checkOutput("mw_rsp",  32'(bus.rsp_valid), 32'h4);
        checkOutput("mw_dout", bus.rsp_dout,       32'h1234_0000);

        // Interleaved reads from requesters 1 and 0
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 10'd3, 32'hFFFF_FFFF, 32'hAAAA_0003);
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 10'd7, 32'hFFFF_FFFF, 32'hBBBB_0007);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 10'd3, '0, '0);
        #1;
        checkOutput("il_ready1", 32'(bus.req_ready), 32'h2);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 10'd7, '0, '0);
        #1;
        checkOutput("il_ready0", 32'(bus.req_ready), 32'h1);
        checkOutput("il_rsp1",   32'(bus.rsp_valid), 32'h2);
        checkOutput("il_dout1",  bus.rsp_dout,       32'hAAAA_0003);
        nextCycle();
        #1;
        checkOutput("il_rsp0",  32'(bus.rsp_valid), 32'h1);
        checkOutput("il_dout0", bus.rsp_dout,       32'hBBBB_0007);

        // Locked burst by requester 1 while requester 0 keeps asking
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 10'd20, 32'hFFFF_FFFF, 32'h1);
        #1;
        checkOutput("lk_pre", 32'(bus.req_ready), 32'h1);
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 10'd21, 32'hFFFF_FFFF, 32'h2);
        applyStimulus(1, 1'b1, 1'b1, 10'd22, 32'hFFFF_FFFF, 32'h3);
        #1;
        checkOutput("lk_first", 32'(bus.req_ready), 32'h2);
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 10'd21, 32'hFFFF_FFFF, 32'h2);
        applyStimulus(1, 1'b1, 1'b1, 10'd23, 32'hFFFF_FFFF, 32'h4);
        #1;
`ifdef LA_SPRAM_ARBITER_LOCK_EN
        checkOutput("lk_second", 32'(bus.req_ready), 32'h2);
`else
        checkOutput("lk_second", 32'(bus.req_ready), 32'h1);
`endif
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 10'd21, 32'hFFFF_FFFF, 32'h2);
        applyStimulus(1, 1'b1, 1'b0, 10'd24, 32'hFFFF_FFFF, 32'h5);
        #1;
        checkOutput("lk_third", 32'(bus.req_ready), 32'h2);
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 10'd21, 32'hFFFF_FFFF, 32'h2);
        #1;
        checkOutput("lk_release", 32'(bus.req_ready), 32'h1);

        // Reset asserted in the cycle after a read is accepted
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 10'd3, '0, '0);
        #1;
        checkOutput("mr_ready", 32'(bus.req_ready), 32'h2);
        nextCycle();
        nreset = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 10'd3, '0, '0);
        #1;
        checkOutput("mr_rsp",   32'(bus.rsp_valid), 32'h0);
        checkOutput("mr_ptr",   32'(dut.ptr),       32'h3);
        checkOutput("mr_ce",    32'(mem_ce),        32'h0);
        checkOutput("mr_ready0", 32'(bus.req_ready), 32'h0);
        nextCycle();
        nreset = 1'b1;
        #1;
        checkOutput("mr_post_rsp", 32'(bus.rsp_valid), 32'h0);

        // Fairness: all four requesters read continuously for 8 cycles
        for (int k = 0; k < 8; k++) begin
            nextCycle();
            for (int r = 0; r < N; r++) begin
                applyStimulus(r, 1'b0, 1'b0, AW'(k), '0, '0);
            end
            #1;
            checkOutput($sformatf("fair_ready%0d", k), 32'(bus.req_ready), 32'(1) << (k % 4));
            checkOutput($sformatf("fair_rsp%0d", k), 32'(bus.rsp_valid),
                        (k == 0) ? 32'h0 : (32'(1) << ((k - 1) % 4)));
        end
        nextCycle();
        #1;
        checkOutput("fair_rsp_last", 32'(bus.rsp_valid), 32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
